// File: rtl/inst_load_ctrl_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM states and
// framing constants of the UART image format.
package inst_load_ctrl_pkg;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        WORD,
        DONE,
        ERROR
    } load_state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/inst_load_ctrl_word_assembler.sv
// Packs incoming UART bytes MSB-first into 32-bit instruction words and flags
// the byte that completes each word.
module inst_load_ctrl_word_assembler
    import inst_load_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  rx_data,
    output logic [31:0] word,
    output logic        word_full
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [23:0] shreg;
    logic [1:0]  byte_idx;

    // The completing byte is merged combinationally so the loader can register
    // the full word on the very edge that accepts its last byte.
    assign word      = {shreg, rx_data};
    assign word_full = shift_en && (byte_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shreg    <= '0;
            byte_idx <= '0;
        end else if (shift_en) begin
            shreg    <= {shreg[15:0], rx_data};
            byte_idx <= byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/inst_load_ctrl.sv
// Boot loader: parses a word-count header from the UART byte stream, writes
// each assembled word to instruction memory and releases the CPU when done.
module inst_load_ctrl
    import inst_load_ctrl_pkg::*;
#(
    parameter int MEM_SIZE       = 512,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [15:0] uart_addr,
    output logic        uart_wr_en,
    output logic [31:0] uart_wdata,
    output logic        recv_done,
    output logic        cpu_reset,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    localparam int              TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]   TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]     MEM_WORDS = 16'(MEM_SIZE);

    load_state_t state, state_next;

    logic [15:0]   count;
    logic [TW-1:0] timer;
    logic [15:0]   hdr_count;
    logic          hdr_bad;
    logic          timed_out;
    logic          last_word;
    logic          shift_en;
    logic          asm_clear;
    logic [31:0]   word;
    logic          word_full;

    assign hdr_count = {count[15:8], rx_data};
    assign hdr_bad   = (hdr_count == 16'd0) || (hdr_count > MEM_WORDS);
    assign timed_out = (timer == TIMER_MAX) && !rx_valid;
    assign shift_en  = rx_valid && (state == WORD);
    assign asm_clear = rx_valid && (state == LEN_LO);
    // words_loaded doubles as the zero-based index of the word being assembled
    assign last_word = word_full && (words_loaded == count - 16'd1);

    inst_load_ctrl_word_assembler u_word_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .shift_en  (shift_en),
        .rx_data   (rx_data),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LEN_HI;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LEN_HI: begin
                if (rx_valid) begin
                    state_next = LEN_LO;
                end
            end
            LEN_LO: begin
                if (rx_valid) begin
                    state_next = hdr_bad ? ERROR : WORD;
                end else if (timed_out) begin
                    state_next = ERROR;
                end
            end
            WORD: begin
                if (last_word) begin
                    state_next = DONE;
                end else if (timed_out) begin
                    state_next = ERROR;
                end
            end
            DONE:    state_next = DONE;
            ERROR:   state_next = ERROR;
            default: state_next = ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            timer        <= '0;
            uart_addr    <= '0;
            uart_wr_en   <= 1'b0;
            uart_wdata   <= '0;
            recv_done    <= 1'b0;
            cpu_reset    <= 1'b1;
            load_error   <= 1'b0;
            words_loaded <= '0;
        end else begin
            uart_wr_en <= 1'b0;

            if ((state == LEN_HI) && rx_valid) begin
                count[15:8] <= rx_data;
            end
            if ((state == LEN_LO) && rx_valid) begin
                count[7:0]   <= rx_data;
                words_loaded <= '0;
            end

            if (word_full) begin
                uart_wr_en   <= 1'b1;
                uart_wdata   <= word;
                uart_addr    <= words_loaded + 16'd1;
                words_loaded <= words_loaded + 16'd1;
            end

            // Idle timer only matters once a header has started arriving
            if (rx_valid || !(state inside {LEN_LO, WORD})) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end

            if (state == DONE) begin
                recv_done <= 1'b1;
                cpu_reset <= 1'b0;
            end
            if (state_next == ERROR) begin
                load_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_load_ctrl.sv
// Scoreboard bench for inst_load_ctrl: expected memory writes are queued by
// the stimulus process and checked by an independent write monitor.
module tb_inst_load_ctrl;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [15:0] uart_addr;
    logic        uart_wr_en;
    logic [31:0] uart_wdata;
    logic        recv_done;
    logic        cpu_reset;
    logic        load_error;
    logic [15:0] words_loaded;

    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  strobe_cyc = -1;
    wr_t exp_q[$];

    inst_load_ctrl #(
        .MEM_SIZE       (512),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .uart_addr    (uart_addr),
        .uart_wr_en   (uart_wr_en),
        .uart_wdata   (uart_wdata),
        .recv_done    (recv_done),
        .cpu_reset    (cpu_reset),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (!reset && uart_wr_en) begin
            strobe_cyc = cyc;
            check_output("recv_done low at strobe", {31'd0, recv_done}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected write: addr=%0d data=0x%08h", uart_addr, uart_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_output("write addr", {16'd0, uart_addr}, {16'd0, e.addr});
                check_output("write data", uart_wdata, e.data);
            end
        end
    end

    task automatic apply_stimulus(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic expect_write(input logic [15:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int budget, output int waited);
        waited = 0;
        while (!recv_done && waited < budget) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, " uart_addr"}, {16'd0, uart_addr}, 32'd0);
        check_output({tag, " uart_wr_en"}, {31'd0, uart_wr_en}, 32'd0);
        check_output({tag, " uart_wdata"}, uart_wdata, 32'd0);
        check_output({tag, " recv_done"}, {31'd0, recv_done}, 32'd0);
        check_output({tag, " cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
        check_output({tag, " load_error"}, {31'd0, load_error}, 32'd0);
        check_output({tag, " words_loaded"}, {16'd0, words_loaded}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int waited;
        logic [15:0] snap_addr;
        logic [31:0] snap_data;
        logic [15:0] snap_words;
        logic [7:0]  img1 [10] = '{8'h00, 8'h02, 8'h20, 8'h10, 8'h00, 8'h50,
                                   8'h20, 8'h11, 8'h03, 8'h20};

        do_reset();
        check_reset_values("reset");

        // Two-word image, bytes back to back (covers byte during strobe cycle)
        expect_write(16'd1, 32'h20100050);
        expect_write(16'd2, 32'h20110320);
        foreach (img1[i]) apply_stimulus(img1[i], 0);
        wait_done(20, waited);
        check_output("t1 recv_done", {31'd0, recv_done}, 32'd1);
        check_output("t1 done one cycle after strobe", cyc, strobe_cyc + 1);
        check_output("t1 cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check_output("t1 words_loaded", {16'd0, words_loaded}, 32'd2);
        check_output("t1 load_error", {31'd0, load_error}, 32'd0);

        // Zero-length header
        do_reset();
        apply_stimulus(8'h00, 0);
        apply_stimulus(8'h00, 3);
        check_output("t2a load_error", {31'd0, load_error}, 32'd1);
        check_output("t2a recv_done", {31'd0, recv_done}, 32'd0);
        check_output("t2a cpu_reset", {31'd0, cpu_reset}, 32'd1);

        // 513 words exceeds memory
        do_reset();
        apply_stimulus(8'h02, 0);
        apply_stimulus(8'h01, 3);
        check_output("t2b load_error", {31'd0, load_error}, 32'd1);
        check_output("t2b recv_done", {31'd0, recv_done}, 32'd0);
        apply_stimulus(8'h11, 0);
        apply_stimulus(8'h22, 0);
        apply_stimulus(8'h33, 0);
        apply_stimulus(8'h44, 3);
        check_output("t2b no load after error", {16'd0, words_loaded}, 32'd0);

        // Exactly 512 words is accepted
        do_reset();
        apply_stimulus(8'h02, 0);
        apply_stimulus(8'h00, 3);
        check_output("t2c 512 accepted", {31'd0, load_error}, 32'd0);

        // Inter-byte timeout after two data bytes
        do_reset();
        apply_stimulus(8'h00, 0);
        apply_stimulus(8'h01, 0);
        apply_stimulus(8'hAB, 0);
        apply_stimulus(8'hCD, 0);
        waited = 0;
        while (!load_error && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check_output("t3 timeout latency", waited, 16);
        check_output("t3 load_error", {31'd0, load_error}, 32'd1);
        check_output("t3 cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check_output("t3 recv_done", {31'd0, recv_done}, 32'd0);

        // Reset in the middle of a 3-word load
        do_reset();
        expect_write(16'd1, 32'hDEADBEEF);
        apply_stimulus(8'h00, 0);
        apply_stimulus(8'h03, 0);
        apply_stimulus(8'hDE, 0);
        apply_stimulus(8'hAD, 0);
        apply_stimulus(8'hBE, 0);
        apply_stimulus(8'hEF, 0);
        apply_stimulus(8'h12, 0);
        apply_stimulus(8'h34, 2);
        check_output("t4 one word before reset", {16'd0, words_loaded}, 32'd1);
        do_reset();
        check_reset_values("t4 after reset");
        expect_write(16'd1, 32'h00C0FFEE);
        apply_stimulus(8'h00, 1);
        apply_stimulus(8'h01, 1);
        apply_stimulus(8'h00, 1);
        apply_stimulus(8'hC0, 1);
        apply_stimulus(8'hFF, 1);
        apply_stimulus(8'hEE, 0);
        wait_done(20, waited);
        check_output("t4 recv_done", {31'd0, recv_done}, 32'd1);
        check_output("t4 words_loaded", {16'd0, words_loaded}, 32'd1);

        // Bytes after completion are ignored
        snap_addr  = 16'd1;
        snap_data  = 32'h00C0FFEE;
        snap_words = 16'd1;
        for (int i = 0; i < 8; i++) apply_stimulus(8'(8'h90 + i), 0);
        repeat (3) @(negedge clk);
        check_output("t5 uart_addr frozen", {16'd0, uart_addr}, {16'd0, snap_addr});
        check_output("t5 uart_wdata frozen", uart_wdata, snap_data);
        check_output("t5 words_loaded frozen", {16'd0, words_loaded}, {16'd0, snap_words});
        check_output("t5 recv_done held", {31'd0, recv_done}, 32'd1);

        // One-word load, all consecutive bytes
        do_reset();
        expect_write(16'd1, 32'hA1B2C3D4);
        apply_stimulus(8'h00, 0);
        apply_stimulus(8'h01, 0);
        apply_stimulus(8'hA1, 0);
        apply_stimulus(8'hB2, 0);
        apply_stimulus(8'hC3, 0);
        apply_stimulus(8'hD4, 0);
        wait_done(20, waited);
        check_output("t6a recv_done", {31'd0, recv_done}, 32'd1);
        check_output("t6a load_error", {31'd0, load_error}, 32'd0);

        // Byte lands exactly in the cycle the idle timer expires
        do_reset();
        expect_write(16'd1, 32'h0BADF00D);
        apply_stimulus(8'h00, 0);
        apply_stimulus(8'h01, 0);
        apply_stimulus(8'h0B, 0);
        apply_stimulus(8'hAD, 15);
        apply_stimulus(8'hF0, 15);
        check_output("t6b no error at expiry", {31'd0, load_error}, 32'd0);
        apply_stimulus(8'h0D, 0);
        wait_done(20, waited);
        check_output("t6b recv_done", {31'd0, recv_done}, 32'd1);
        check_output("t6b load_error", {31'd0, load_error}, 32'd0);

        repeat (3) @(negedge clk);
        check_output("scoreboard drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
